lsu_mem_master: RTL and testbench

//  Load/store initiator that sits between the core's memory stage and the word-wide data RAM.

---
 rtl/lsu_mem_master_if.sv | 31 +++
 rtl/lsu_mem_master.sv | 126 ++++++++++++
 tb/tb_lsu_mem_master.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Signal bundle between the load/store unit, the core's memory stage and the word-wide data RAM.
interface lsu_mem_master_if #(
  parameter int unsigned ADDRESS_WIDTH = 1024
);
  localparam int unsigned AW = $clog2(ADDRESS_WIDTH);

  logic          req;
  logic          we;
  logic [2:0]    funct3;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [31:0]   rdata;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;

  modport master (
    input  req, we, funct3, addr, wdata, mem_read_data,
    output busy, done, err, rdata, mem_read, mem_write, mem_address, mem_write_data
  );

  modport slave (
    output req, we, funct3, addr, wdata, mem_read_data,
    input  busy, done, err, rdata, mem_read, mem_write, mem_address, mem_write_data
  );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns LB/LH/LW/LBU/LHU/SB/SH/SW into word RAM cycles,
// using read-modify-write for sub-word stores.
module lsu_mem_master #(
  parameter int unsigned ADDRESS_WIDTH = 1024
) (
  input logic                clk,
  input logic                rst,
  lsu_mem_master_if.master   bus
);
  localparam int unsigned AW = $clog2(ADDRESS_WIDTH);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  state_e        state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   merge_q, merge_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          capture;

  logic          is_byte, is_half, is_word, req_err;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_ext, store_word;

  // Request checks operate on the live inputs because they are only used in IDLE.
  always_comb begin
    is_byte = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b100);
    is_half = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b101);
    is_word = (bus.funct3 == 3'b010);
    req_err = !(is_byte || is_half || is_word)
           || (bus.we && bus.funct3[2])
           || (is_half && bus.addr[0])
           || (is_word && (bus.addr[1:0] != 2'b00))
           || (bus.addr[31:AW+2] != '0);
  end

  always_comb begin
    byte_sel = 8'(bus.mem_read_data >> {addr_q[1:0], 3'b000});
    half_sel = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    unique case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = bus.mem_read_data;
    endcase
  end

  always_comb begin
    store_word = merge_q;
    unique case (f3_q[1:0])
      2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          capture = 1'b1;
          err_d   = req_err;
          if (req_err)                  state_d = StDone;
          else if (bus.we && is_word)   state_d = StWr;
          else                          state_d = StRd;
        end
      end
      StRd: begin
        if (we_q) begin
          merge_d = bus.mem_read_data;
          state_d = StWr;
        end else begin
          rdata_d = load_ext;
          state_d = StDone;
        end
      end
      StWr:    state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (capture) begin
        we_q    <= bus.we;
        f3_q    <= bus.funct3;
        addr_q  <= bus.addr[AW+1:0];
        wdata_q <= bus.wdata;
      end
    end
  end

  always_comb begin
    bus.busy           = (state_q != StIdle);
    bus.done           = (state_q == StDone);
    bus.err            = (state_q == StDone) && err_q;
    bus.rdata          = rdata_q;
    bus.mem_read       = (state_q == StRd);
    bus.mem_write      = (state_q == StWr);
    bus.mem_address    = addr_q[AW+1:2];
    bus.mem_write_data = (state_q == StWr) ? store_word : 32'h0;
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: vector table of accesses plus hold-req and mid-RMW reset sequences.
module tb_lsu_mem_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_mem_master_if #(.ADDRESS_WIDTH(1024)) bus ();

  lsu_mem_master #(.ADDRESS_WIDTH(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:1023];
  assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_address] : 32'h0;
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address] <= bus.mem_write_data;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          done_cyc;
    int          rd_cyc;
    int          wr_cyc;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wr_data;
  } vec_t;

  int          got_done, got_rd, got_wr;
  logic        got_err, overlap;
  logic [31:0] got_wdata, got_rdata, ma_rd, ma_wr;

  // Starts at a negedge; returns at the negedge of the done cycle (or after the cycle budget).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = wd;
    got_done = 0; got_rd = 0; got_wr = 0; got_err = 1'b0; overlap = 1'b0;
    got_wdata = 32'h0; got_rdata = 32'h0; ma_rd = 32'h0; ma_wr = 32'h0;
    @(negedge clk);
    bus.req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.mem_read && got_rd == 0) begin
        got_rd = c; ma_rd = 32'(bus.mem_address);
      end
      if (bus.mem_write && got_wr == 0) begin
        got_wr = c; ma_wr = 32'(bus.mem_address); got_wdata = bus.mem_write_data;
      end
      if (bus.mem_read && bus.mem_write) overlap = 1'b1;
      if (bus.done) begin
        got_done = c; got_err = bus.err; got_rdata = bus.rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  vec_t vecs [18];
  logic [7:0] wr_mask, done_mask, busy_mask;

  initial begin
    vecs[0]  = '{1'b1, 3'b010, 32'h10,   32'hDEADBEEF, 2, 0, 1, 1'b0, 32'h00000000, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b010, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{1'b0, 3'b000, 32'h13,   32'h0,        2, 1, 0, 1'b0, 32'hFFFFFFDE, 32'h0};
    vecs[3]  = '{1'b0, 3'b100, 32'h13,   32'h0,        2, 1, 0, 1'b0, 32'h000000DE, 32'h0};
    vecs[4]  = '{1'b0, 3'b001, 32'h12,   32'h0,        2, 1, 0, 1'b0, 32'hFFFFDEAD, 32'h0};
    vecs[5]  = '{1'b0, 3'b101, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'h0000BEEF, 32'h0};
    vecs[6]  = '{1'b0, 3'b000, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'hFFFFFFEF, 32'h0};
    vecs[7]  = '{1'b1, 3'b000, 32'h11,   32'hAAAAAA55, 3, 1, 2, 1'b0, 32'hFFFFFFEF, 32'hDEAD55EF};
    vecs[8]  = '{1'b0, 3'b010, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'hDEAD55EF, 32'h0};
    vecs[9]  = '{1'b1, 3'b001, 32'h12,   32'hFFFF1234, 3, 1, 2, 1'b0, 32'hDEAD55EF, 32'h123455EF};
    vecs[10] = '{1'b0, 3'b010, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'h123455EF, 32'h0};
    vecs[11] = '{1'b0, 3'b101, 32'h12,   32'h0,        2, 1, 0, 1'b0, 32'h00001234, 32'h0};
    vecs[12] = '{1'b0, 3'b010, 32'h11,   32'h0,        1, 0, 0, 1'b1, 32'h00001234, 32'h0};
    vecs[13] = '{1'b1, 3'b001, 32'h13,   32'h5678,     1, 0, 0, 1'b1, 32'h00001234, 32'h0};
    vecs[14] = '{1'b0, 3'b011, 32'h10,   32'h0,        1, 0, 0, 1'b1, 32'h00001234, 32'h0};
    vecs[15] = '{1'b1, 3'b100, 32'h10,   32'h77,       1, 0, 0, 1'b1, 32'h00001234, 32'h0};
    vecs[16] = '{1'b0, 3'b010, 32'h1000, 32'h0,        1, 0, 0, 1'b1, 32'h00001234, 32'h0};
    vecs[17] = '{1'b0, 3'b010, 32'h10,   32'h0,        2, 1, 0, 1'b0, 32'h123455EF, 32'h0};

    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000; bus.addr = 32'h0; bus.wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ctrl", 32'({bus.busy, bus.done, bus.err, bus.mem_read, bus.mem_write}), 32'h0);
    chk("reset_rdata", bus.rdata, 32'h0);
    chk("reset_addr", 32'(bus.mem_address), 32'h0);
    chk("reset_wdata", bus.mem_write_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("v%0d_done_cyc", i), 32'(got_done), 32'(vecs[i].done_cyc));
      chk($sformatf("v%0d_rd_cyc", i), 32'(got_rd), 32'(vecs[i].rd_cyc));
      chk($sformatf("v%0d_wr_cyc", i), 32'(got_wr), 32'(vecs[i].wr_cyc));
      chk($sformatf("v%0d_err", i), 32'(got_err), 32'(vecs[i].err));
      chk($sformatf("v%0d_rdata", i), got_rdata, vecs[i].rdata);
      chk($sformatf("v%0d_overlap", i), 32'(overlap), 32'h0);
      if (vecs[i].rd_cyc != 0) chk($sformatf("v%0d_rd_addr", i), ma_rd, vecs[i].addr >> 2);
      if (vecs[i].wr_cyc != 0) begin
        chk($sformatf("v%0d_wr_addr", i), ma_wr, vecs[i].addr >> 2);
        chk($sformatf("v%0d_wr_data", i), got_wdata, vecs[i].wr_data);
      end
      @(negedge clk);
      chk($sformatf("v%0d_idle_after", i), 32'({bus.busy, bus.done}), 32'h0);
    end

    // req held high: second SW starts the cycle after DONE
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h20; bus.wdata = 32'hA5A5A5A5;
    wr_mask = 8'h0; done_mask = 8'h0; busy_mask = 8'h0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      wr_mask[c]   = bus.mem_write;
      done_mask[c] = bus.done;
      busy_mask[c] = bus.busy;
    end
    bus.req = 1'b0;
    chk("hold_wr_mask", 32'(wr_mask), 32'h12);
    chk("hold_done_mask", 32'(done_mask), 32'h24);
    chk("hold_busy_mask", 32'(busy_mask), 32'h36);
    @(negedge clk);
    chk("hold_idle", 32'(bus.busy), 32'h0);
    chk("hold_mem", mem[8], 32'hA5A5A5A5);

    // Reset during the write phase of an SB
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h20; bus.wdata = 32'h11;
    @(negedge clk);
    bus.req = 1'b0;
    chk("rst_seq_rd", 32'(bus.mem_read), 32'h1);
    @(negedge clk);
    chk("rst_seq_wr", 32'(bus.mem_write), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_seq_write_drop", 32'(bus.mem_write), 32'h0);
    chk("rst_seq_busy", 32'(bus.busy), 32'h0);
    chk("rst_seq_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_seq_mem", mem[8], 32'hA5A5A5A5);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    chk("rst_seq_reload", got_rdata, 32'hA5A5A5A5);
    chk("rst_seq_reload_done", 32'(got_done), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
